// File: rtl/rl_fifo_obuf.sv
`default_nettype none
// ============================================================================
// Module      : rl_fifo_obuf
// Description : Two-entry output buffer holding the head words of the FIFO.
//               Head word is presented on data_o; occupancy on occ_o.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_fifo_obuf #(
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DBITS-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [DBITS-1:0] data_o
);

  logic [DBITS-1:0] entry_q [2];
  logic [DBITS-1:0] entry_d [2];
  logic             rptr_q, rptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_pop;
  logic             do_push;
  logic             wptr;

  // Next-state for the two slots, read pointer and occupancy.
  always_comb begin
    do_pop     = pop_i & (occ_q != 2'd0);
    // A full buffer only takes a new word when the head leaves in the same cycle.
    do_push    = push_i & ((occ_q != 2'd2) | do_pop);
    // Slot after the last valid one; equals the head slot when full (head is leaving).
    wptr       = rptr_q ^ occ_q[0];
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    if (do_push) begin
      entry_d[wptr] = push_data_i;
    end
    if (do_pop) begin
      rptr_d = ~rptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer state register; slots clear on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rptr_q     <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign data_o = entry_q[rptr_q];

endmodule
`default_nettype wire

// File: rtl/rl_fifo_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rl_fifo_1rw_ctrl
// Description : FIFO controller over a single-port (1RW) RAM with a 2-entry
//               output buffer, bypass path and read prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_fifo_1rw_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  input  logic [DBITS-1:0]       in_data_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [DBITS-1:0]       out_data_o,
  input  logic                   out_ready_i,
  output logic [ABITS+1:0]       count_o,
  output logic [ABITS-1:0]       ram_addr_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [DBITS-1:0]       ram_din_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int BEBITS = (DBITS + 7) / 8;
  localparam logic [ABITS:0] RAM_FULL = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   ram_cnt_q, ram_cnt_d;
  logic             inflt_q, inflt_d;
  logic [ABITS+1:0] count_q, count_d;

  logic [1:0]       occ;
  logic [1:0]       occ_after_pop;
  logic             rd_pri;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             ram_wr;
  logic             ram_rd;
  logic             obuf_push;
  logic [DBITS-1:0] obuf_data;

  // Handshakes, access arbitration and pointer/counter next-state.
  always_comb begin
    // Buffer and in-flight read both empty while RAM holds data: the RAM
    // must be read now, so the producer is stalled for this cycle.
    rd_pri        = (ram_cnt_q != '0) & (occ == 2'd0) & ~inflt_q;
    in_ready_o    = (ram_cnt_q != RAM_FULL) & ~rd_pri;
    out_valid_o   = (occ != 2'd0);
    push          = in_valid_i & in_ready_o;
    pop           = out_valid_o & out_ready_i;
    occ_after_pop = occ - {1'b0, pop};
    // Bypass only while nothing older sits in RAM or in flight.
    bypass        = push & (ram_cnt_q == '0) & ~inflt_q & (occ_after_pop < 2'd2);
    ram_wr        = push & ~bypass;
    // Prefetch keeps buffer + in-flight read at most two words.
    ram_rd        = ~ram_wr & (ram_cnt_q != '0) &
                    ((occ_after_pop + {1'b0, inflt_q}) < 2'd2);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    inflt_d   = ram_rd;
    count_d   = count_q + {{(ABITS+1){1'b0}}, push} - {{(ABITS+1){1'b0}}, pop};
    if (ram_wr) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
    if (ram_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end

    // Bypass and read return never coincide: bypass requires no read in flight.
    obuf_push = bypass | inflt_q;
    obuf_data = inflt_q ? ram_dout_i : in_data_i;

    ram_we_o   = ram_wr;
    ram_addr_o = ram_wr ? wr_ptr_q : rd_ptr_q;
    ram_be_o   = {BEBITS{1'b1}};
    ram_din_o  = in_data_i;
  end

  // Controller state register; clearing inflt drops any pending read return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      inflt_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      inflt_q   <= inflt_d;
      count_q   <= count_d;
    end
  end

  rl_fifo_obuf #(
    .DBITS (DBITS)
  ) u_obuf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (obuf_push),
    .push_data_i (obuf_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .data_o      (out_data_o)
  );

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rl_fifo_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rl_fifo_1rw_ctrl
// Description : Directed self-checking bench for rl_fifo_1rw_ctrl
//               (ABITS=2, DBITS=8) with a behavioural 1-cycle-read RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rl_fifo_1rw_ctrl;

  localparam int ABITS = 2;
  localparam int DBITS = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [DBITS-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [DBITS-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [ABITS+1:0] count;
  logic [ABITS-1:0] ram_addr;
  logic             ram_we;
  logic [0:0]       ram_be;
  logic [DBITS-1:0] ram_din;
  logic [DBITS-1:0] ram_dout = '0;
  logic [DBITS-1:0] ram_mem [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural 1RW RAM: write, or registered read visible next cycle.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  rl_fifo_1rw_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (count),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; the bench always stands at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int low;
    int cyc;
    logic p;
    logic q;

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_ram_we", 32'(ram_we), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single push into empty FIFO goes through the bypass.
    in_valid = 1'b1; in_data = 8'h11; #1;
    check_eq("byp_ram_we", 32'(ram_we), 0);
    tick();
    in_valid = 1'b0; #1;
    check_eq("byp_out_valid", 32'(out_valid), 1);
    check_eq("byp_out_data", 32'(out_data), 32'h11);
    check_eq("byp_count", 32'(count), 1);

    // Fill: two bypass words, four RAM writes at addresses 0..3.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i); #1;
      check_eq("fill_in_ready", 32'(in_ready), 1);
      check_eq("fill_ram_we", 32'(ram_we), (i >= 3) ? 1 : 0);
      if (i >= 3) check_eq("fill_ram_addr", 32'(ram_addr), 32'(i - 3));
      tick();
    end
    in_data = 8'hEE; #1;
    check_eq("full_in_ready", 32'(in_ready), 0);
    check_eq("full_count", 32'(count), 6);
    check_eq("full_ram_we", 32'(ram_we), 0);
    tick();
    check_eq("full_hold_count", 32'(count), 6);
    in_valid = 1'b0;

    // Drain with a pop every cycle: no bubbles, push order preserved.
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_eq("drain_valid", 32'(out_valid), 1);
      check_eq("drain_data", 32'(out_data), 32'(k));
      tick();
    end
    #1;
    check_eq("empty_valid", 32'(out_valid), 0);
    check_eq("empty_count", 32'(count), 0);
    tick();
    check_eq("empty_pop_count", 32'(count), 0);
    out_ready = 1'b0;

    // Streaming 0x00..0x3F with push and pop every cycle.
    do_reset();
    sent = 0; recv = 0; low = 0; cyc = 0;
    while (recv < 64 && cyc < 400) begin
      in_valid = (sent < 64); in_data = 8'(sent); out_ready = 1'b1; #1;
      p = in_valid & in_ready;
      q = out_valid & out_ready;
      if (q) begin check_eq("stream_data", 32'(out_data), 32'(recv)); recv++; end
      if (in_valid && !in_ready) low++;
      if (p) sent++;
      tick(); cyc++;
    end
    check_eq("stream_recv", 32'(recv), 64);
    check_eq("stream_in_ready_drops", 32'(low), 0);

    // Streaming with a throttled consumer to exercise the RAM path.
    do_reset();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 64 && cyc < 800) begin
      in_valid = (sent < 64); in_data = 8'(sent + 8'h40); out_ready = (cyc % 3) != 0; #1;
      p = in_valid & in_ready;
      q = out_valid & out_ready;
      if (q) begin check_eq("throttle_data", 32'(out_data), 32'(recv + 8'h40)); recv++; end
      if (p) sent++;
      tick(); cyc++;
    end
    check_eq("throttle_recv", 32'(recv), 64);
    out_ready = 1'b0;
    #1;
    check_eq("throttle_count", 32'(count), 0);

    // Reset the cycle after a read issue; the pending return must be dropped.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i); tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check_eq("rdiss_ram_we", 32'(ram_we), 0);
    check_eq("rdiss_ram_addr", 32'(ram_addr), 0);
    tick();
    out_ready = 1'b0;
    rst_n = 1'b0; #1;
    check_eq("midrst_count", 32'(count), 0);
    check_eq("midrst_valid", 32'(out_valid), 0);
    check_eq("midrst_in_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_valid = 1'b0; #1;
    check_eq("postrst_valid", 32'(out_valid), 1);
    check_eq("postrst_data", 32'(out_data), 32'hAA);
    check_eq("postrst_count", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rl_fifo_1rw_ctrl.md
RL_FIFO_1RW_CTRL -- requirements
Module: rl_fifo_1rw_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 10: RAM address bits; RAM depth is 2**ABITS.
REQ-002 SHALL have parameter DBITS, default 32: data width in bits.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 in_valid_i  input  1  producer holds a word.
REQ-006 in_data_i  input  DBITS  producer word.
REQ-007 in_ready_o  output  1  controller accepts the word this cycle.
REQ-008 out_valid_o  output  1  head word available.
REQ-009 out_data_o  output  DBITS  head word.
REQ-010 out_ready_i  input  1  consumer takes the head word.
REQ-011 count_o  output  ABITS+2  total words held (RAM + output buffer + in-flight read).
REQ-012 ram_addr_o  output  ABITS  to the 1RW RAM wrapper.
REQ-013 ram_we_o  output  1  RAM write enable.
REQ-014 ram_be_o  output  (DBITS+7)/8  RAM byte enables.
REQ-015 ram_din_o  output  DBITS  RAM write data.
REQ-016 ram_dout_i  input  DBITS  RAM read data, valid the cycle after the read is issued.

Function
REQ-017 Transfer SHALL occur on in_valid_i&in_ready_o (push) and out_valid_o&out_ready_i (pop); words SHALL leave in push order.
REQ-018 Storage SHALL be the RAM (2**ABITS words) plus a 2-entry output buffer; occ = buffered words, inflt = 1 while a read is in flight.
REQ-019 Per cycle, the RAM SHALL perform at most one access: write, read, or idle.
REQ-020 rd_pri = (ram_cnt!=0) & (occ==0) & !inflt; when rd_pri, a read SHALL be issued and in_ready_o SHALL be 0.
REQ-021 in_ready_o SHALL be (ram_cnt != 2**ABITS) & !rd_pri, combinational from state only.
REQ-022 Bypass: a push with ram_cnt==0, !inflt and occ<2 (after this cycle's pop) SHALL go directly into the output buffer with no RAM write.
REQ-023 Any other push SHALL write ram_din_o=in_data_i at wr_ptr with ram_we_o=1 and ram_be_o all ones; wr_ptr increments mod 2**ABITS.
REQ-024 Prefetch: a read SHALL issue at rd_ptr when no write occurs, ram_cnt!=0 and occ+inflt<2 (counting this cycle's pop); rd_ptr increments mod 2**ABITS.
REQ-025 Read data SHALL be captured into the output buffer on the edge ending the cycle after issue.
REQ-026 ram_addr_o SHALL be wr_ptr on a write cycle, otherwise rd_ptr; ram_we_o=0 when not writing.
REQ-027 Latency: bypass push at cycle t -> out_valid_o at t+1; RAM-path push at t (no contention) -> read at t+1 -> out_valid_o at t+3 if occ was 0.
REQ-028 Simultaneous push and pop SHALL both complete; pop with concurrent read return SHALL not lose data.
REQ-029 count_o SHALL increment on push, decrement on pop, unchanged on both; maximum 2**ABITS+2.
REQ-030 in_valid_i while in_ready_o=0 and out_ready_i while out_valid_o=0 SHALL have no effect.

Reset
REQ-031 On rst_ni low, immediately: wr_ptr, rd_ptr, ram_cnt, occ, inflt, count_o = 0; out_valid_o=0; ram_we_o=0; in_ready_o=1.
REQ-032 Reset mid-operation SHALL discard all contents, including an in-flight read, whose return is ignored.
REQ-033 out_data_o SHALL be 0 after reset.

Structure
REQ-034 No shared package; depth/count widths are derived locally from ABITS.
REQ-035 The 2-entry output buffer SHALL be sub-module rl_fifo_obuf (push/pop/occ, DBITS parameter).
REQ-036 The RAM itself is not instantiated here; a top level connects ram_* to the 1RW RAM wrapper.

Verification (ABITS=2, DBITS=8, RAM behavioural model with 1-cycle read)
REQ-037 Push 0x11 into empty, out_ready_i=0 -> no RAM write; out_valid_o=1, out_data_o=0x11 next cycle; count_o=1.
REQ-038 Push 0x01..0x06 back-to-back, out_ready_i=0 -> 0x01,0x02 bypass, 0x03..0x06 written to RAM; in_ready_o=0 after 6th push; count_o=6.
REQ-039 From full, pop every cycle with pushes held -> pops 0x01..0x06 in order, no bubbles after the first RAM read returns.
REQ-040 Continuous push and pop, 0x00..0x3F streaming -> output matches input order; in_ready_o drops only on rd_pri cycles.
REQ-041 Assert rst_ni low in the cycle after a read issue -> count_o=0, out_valid_o=0; push 0xAA after release -> 0xAA is the next word out.
REQ-042 Push while in_ready_o=0 and pop while out_valid_o=0 -> count_o and contents unchanged.
